// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data access.
// Data wins by default; a streak limiter forces a fetch after MAX_D_STREAK back-to-back data
// grants while a fetch is waiting. if_abort squashes the ready of an in-flight fetch.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MEM_LAT      = 2,
  parameter int unsigned MAX_D_STREAK = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_abort,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  // Last value of the WAIT counter; WAIT lasts MEM_LAT-1 cycles (none when MEM_LAT is 1).
  localparam int unsigned LatLastInt = (MEM_LAT > 1) ? MEM_LAT - 2 : 0;
  localparam logic [2:0]  LatLast    = 3'(LatLastInt);
  localparam logic [2:0]  StreakMax  = 3'(MAX_D_STREAK);

  logic [1:0]        state_q, state_d;
  logic              gnt_fetch_q, gnt_fetch_d;
  logic              abort_q, abort_d;
  logic [2:0]        streak_q, streak_d;
  logic [2:0]        lat_q, lat_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              streak_hit;

  // Fetch is forced once data has had its full streak while a live fetch waits.
  assign streak_hit = (streak_q == StreakMax) && if_req && !if_abort;

  // Next-state: arbitration in IDLE, latency sequencing, abort tracking for fetches.
  always_comb begin
    state_d     = state_q;
    gnt_fetch_d = gnt_fetch_q;
    abort_d     = abort_q;
    streak_d    = streak_q;
    lat_d       = lat_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      StIdle: begin
        abort_d = 1'b0;
        if (d_req && !streak_hit) begin
          state_d     = StIssue;
          gnt_fetch_d = 1'b0;
          mem_addr_d  = d_addr;
          mem_we_d    = d_we;
          mem_wdata_d = d_wdata;
          if (!if_req) begin
            streak_d = 3'd0;
          end else if (streak_q != StreakMax) begin
            streak_d = streak_q + 3'd1;
          end
        end else if (if_req && !if_abort) begin
          state_d     = StIssue;
          gnt_fetch_d = 1'b1;
          mem_addr_d  = if_addr;
          mem_we_d    = 1'b0;
          streak_d    = 3'd0;
        end
      end
      StIssue: begin
        lat_d = 3'd0;
        if (gnt_fetch_q && if_abort) abort_d = 1'b1;
        if (mem_we_q || (MEM_LAT == 1)) begin
          state_d = StDone;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (gnt_fetch_q && if_abort) abort_d = 1'b1;
        if (lat_q == LatLast) begin
          state_d = StDone;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
        abort_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered memory request, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      gnt_fetch_q <= 1'b0;
      abort_q     <= 1'b0;
      streak_q    <= 3'd0;
      lat_q       <= 3'd0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_fetch_q <= gnt_fetch_d;
      abort_q     <= abort_d;
      streak_q    <= streak_d;
      lat_q       <= lat_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Outputs: ready pulses in DONE with read data passed straight through from the memory.
  always_comb begin
    mem_en    = (state_q == StIssue);
    mem_we    = mem_we_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    // An abort arriving in DONE itself still squashes the fetch.
    if_ready  = (state_q == StDone) && gnt_fetch_q && !abort_q && !if_abort;
    d_ready   = (state_q == StDone) && !gnt_fetch_q;
    if_rdata  = if_ready ? mem_rdata : '0;
    d_rdata   = (d_ready && !mem_we_q) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: directed requester sequences push expected memory issues and ready pulses
// (with the cycle they must occur in); a negedge monitor pops and compares them.
module tb_mem_port_arbiter;

  logic        clk, rst_n;
  logic        if_req, if_abort, if_ready;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_ready;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .MAX_D_STREAK(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_abort(if_abort),
    .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  typedef struct { int cyc; logic we; logic [31:0] addr; logic [31:0] wdata; } mem_exp_t;
  typedef struct { int cyc; logic is_fetch; logic chk; logic [31:0] rdata; } rdy_exp_t;

  mem_exp_t mem_q[$];
  rdy_exp_t rdy_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int c0;
  bit prev_en = 1'b0;
  bit ok;
  mem_exp_t me;
  rdy_exp_t re;

  // Memory model: read data is a fixed scramble of the held address.
  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction
  assign mem_rdata = rd_model(mem_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_mem(input int c, input logic we, input logic [31:0] a, input logic [31:0] w);
    mem_exp_t e;
    e.cyc = c; e.we = we; e.addr = a; e.wdata = w;
    mem_q.push_back(e);
  endtask

  task automatic push_rdy(input int c, input logic f, input logic chk, input logic [31:0] d);
    rdy_exp_t e;
    e.cyc = c; e.is_fetch = f; e.chk = chk; e.rdata = d;
    rdy_q.push_back(e);
  endtask

  // Monitor: compares every issue and ready pulse against the scoreboard, plus invariants.
  always @(negedge clk) begin
    if (mem_en) begin
      if (mem_q.size() == 0) begin
        check("unexpected_mem_en", 32'(mem_en), 32'd0);
      end else begin
        me = mem_q.pop_front();
        check("issue_cycle", 32'(cyc), 32'(me.cyc));
        check("issue_we", 32'(mem_we), 32'(me.we));
        check("issue_addr", mem_addr, me.addr);
        if (me.we) check("issue_wdata", mem_wdata, me.wdata);
      end
    end
    if (mem_en && prev_en) check("mem_en_back_to_back", 32'(prev_en), 32'd0);
    if (if_ready && d_ready) check("both_ready", 32'({if_ready, d_ready}), 32'd0);
    if (if_ready || d_ready) begin
      if (rdy_q.size() == 0) begin
        check("unexpected_ready", 32'({if_ready, d_ready}), 32'd0);
      end else begin
        re = rdy_q.pop_front();
        check("ready_cycle", 32'(cyc), 32'(re.cyc));
        check("ready_port_is_fetch", 32'(if_ready), 32'(re.is_fetch));
        if (re.is_fetch) check("if_rdata", if_rdata, re.rdata);
        else if (re.chk) check("d_rdata", d_rdata, re.rdata);
      end
    end
    prev_en = mem_en;
  end

  // Waits (bounded) for the given port's ready, then steps to just after the next edge.
  task automatic wait_rdy(input logic fetch, output bit got);
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (fetch ? if_ready : d_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check(fetch ? "if_ready_timeout" : "d_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic d_seq(input int n, input logic we, input logic [31:0] base,
                       input logic [31:0] wd);
    bit g;
    for (int i = 0; i < n; i++) begin
      d_req   = 1'b1;
      d_we    = we;
      d_addr  = base + 32'(4 * i);
      d_wdata = wd + 32'(i);
      wait_rdy(1'b0, g);
      if (!g) break;
    end
    d_req = 1'b0;
  endtask

  task automatic f_seq(input int n, input logic [31:0] base);
    bit g;
    for (int i = 0; i < n; i++) begin
      if_req  = 1'b1;
      if_addr = base + 32'(4 * i);
      wait_rdy(1'b1, g);
      if (!g) break;
    end
    if_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; if_req = 1'b0; if_addr = '0; if_abort = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    #1 rst_n = 1'b0;
    #1;
    check("reset_ctrl", 32'({mem_en, mem_we, if_ready, d_ready}), 32'd0);
    check("reset_addr", mem_addr, 32'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    idle(2);
    check("post_reset_idle", 32'({mem_en, if_ready, d_ready}), 32'd0);

    // Plain fetch.
    c0 = cyc;
    push_mem(c0 + 1, 1'b0, 32'h0040_0000, 32'd0);
    push_rdy(c0 + 3, 1'b1, 1'b1, rd_model(32'h0040_0000));
    f_seq(1, 32'h0040_0000);
    idle(3);

    // Fetch aborted during WAIT; the redirected fetch issues from IDLE at c0+4.
    c0 = cyc;
    push_mem(c0 + 1, 1'b0, 32'h0040_0000, 32'd0);
    push_mem(c0 + 5, 1'b0, 32'h0040_0100, 32'd0);
    push_rdy(c0 + 7, 1'b1, 1'b1, rd_model(32'h0040_0100));
    if_req = 1'b1; if_addr = 32'h0040_0000;
    idle(2);
    if_abort = 1'b1; if_addr = 32'h0040_0100;
    idle(1);
    if_abort = 1'b0;
    wait_rdy(1'b1, ok);
    if_req = 1'b0;
    idle(3);

    // Simultaneous load and fetch: data first.
    c0 = cyc;
    push_mem(c0 + 1, 1'b0, 32'h1000_0004, 32'd0);
    push_rdy(c0 + 3, 1'b0, 1'b1, rd_model(32'h1000_0004));
    push_mem(c0 + 5, 1'b0, 32'h0040_0000, 32'd0);
    push_rdy(c0 + 7, 1'b1, 1'b1, rd_model(32'h0040_0000));
    fork
      d_seq(1, 1'b0, 32'h1000_0004, 32'd0);
      f_seq(1, 32'h0040_0000);
    join
    idle(3);

    // Store: ready two cycles after grant.
    c0 = cyc;
    push_mem(c0 + 1, 1'b1, 32'h1000_0008, 32'hDEAD_BEEF);
    push_rdy(c0 + 2, 1'b0, 1'b0, 32'd0);
    d_seq(1, 1'b1, 32'h1000_0008, 32'hDEAD_BEEF);
    idle(3);

    // Streak limiter: grant order D, D, I, D, D, I.
    c0 = cyc;
    push_mem(c0 + 1,  1'b0, 32'h1000_0010, 32'd0);
    push_rdy(c0 + 3,  1'b0, 1'b1, rd_model(32'h1000_0010));
    push_mem(c0 + 5,  1'b0, 32'h1000_0014, 32'd0);
    push_rdy(c0 + 7,  1'b0, 1'b1, rd_model(32'h1000_0014));
    push_mem(c0 + 9,  1'b0, 32'h0040_0200, 32'd0);
    push_rdy(c0 + 11, 1'b1, 1'b1, rd_model(32'h0040_0200));
    push_mem(c0 + 13, 1'b0, 32'h1000_0018, 32'd0);
    push_rdy(c0 + 15, 1'b0, 1'b1, rd_model(32'h1000_0018));
    push_mem(c0 + 17, 1'b0, 32'h1000_001C, 32'd0);
    push_rdy(c0 + 19, 1'b0, 1'b1, rd_model(32'h1000_001C));
    push_mem(c0 + 21, 1'b0, 32'h0040_0204, 32'd0);
    push_rdy(c0 + 23, 1'b1, 1'b1, rd_model(32'h0040_0204));
    fork
      d_seq(4, 1'b0, 32'h1000_0010, 32'd0);
      f_seq(2, 32'h0040_0200);
    join
    idle(3);

    // Reset during WAIT of a load: outputs clear at once, no ready; the load re-issues.
    c0 = cyc;
    push_mem(c0 + 1, 1'b0, 32'h1000_0020, 32'd0);
    push_mem(c0 + 4, 1'b0, 32'h1000_0020, 32'd0);
    push_rdy(c0 + 6, 1'b0, 1'b1, rd_model(32'h1000_0020));
    fork
      d_seq(1, 1'b0, 32'h1000_0020, 32'd0);
      begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midreset_ctrl", 32'({mem_en, mem_we, if_ready, d_ready}), 32'd0);
        check("midreset_addr", mem_addr, 32'd0);
        check("midreset_rdata", if_rdata | d_rdata | mem_wdata, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
      end
    join
    idle(6);

    check("mem_queue_drained", 32'(mem_q.size()), 32'd0);
    check("ready_queue_drained", 32'(rdy_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port instruction/data memory between the IF stage (instruction fetch, read-only) and the MEM stage (lw/sw data access).
- Sits between the pipeline's fetch and memory stages and the memory macro.
- Each requester uses a req/ready handshake: it holds req and its request fields stable until ready.
- Data has priority; a streak limiter guarantees fetch progress. An abort input discards a stale fetch after a taken branch or jump.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, read latency of the memory: cycles from the mem_en cycle to valid mem_rdata. Legal range is 1..7.
- MAX_D_STREAK, 2, maximum consecutive data grants while if_req is pending. Legal range is 1..7.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  ADDR_W  fetch address.
- if_abort  in  1  discard the current or pending fetch (branch/jump flush).
- if_ready  out  1  one-cycle pulse: fetch done.
- if_rdata  out  DATA_W  fetched word; valid only while if_ready=1.
- d_req  in  1  data request; held until d_ready.
- d_we  in  1  1 = store (sw), 0 = load (lw).
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_ready  out  1  one-cycle pulse: data access done.
- d_rdata  out  DATA_W  load data; valid only while d_ready=1 and d_we=0.
- mem_en  out  1  one-cycle issue strobe.
- mem_we  out  1  write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  registered address, held through the transaction.
- mem_wdata  out  DATA_W  registered write data, held through the transaction.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset:
  - Asynchronous, rst_n=0.
  - State goes to IDLE; streak counter, latency counter and abort flag clear.
  - All outputs are 0.
  - Reset mid-transaction drops the transaction silently: no ready pulse follows.
- States:
  - IDLE: arbitrate.
  - ISSUE: mem_en=1 for exactly one cycle.
  - WAIT: count latency.
  - DONE: pulse ready, then return to IDLE.
- Arbitration in IDLE, cycle t:
  - Data is granted if d_req=1, unless streak==MAX_D_STREAK and if_req=1 and if_abort=0; in that case fetch is granted.
  - Otherwise fetch is granted if if_req=1 and if_abort=0.
  - With no grant, stay in IDLE.
  - Grant registers mem_addr, mem_we (d_we for data, 0 for fetch) and mem_wdata at edge t.
- Streak counter:
  - On a data grant with if_req=1: increments, saturating at MAX_D_STREAK.
  - On a fetch grant, or a data grant with if_req=0: clears.
- Timing:
  - ISSUE occurs in cycle t+1.
  - Read: WAIT for MEM_LAT-1 cycles, then DONE in cycle t+1+MEM_LAT.
  - Write: DONE in cycle t+2, regardless of MEM_LAT.
  - In DONE, the granted port's ready=1 and its rdata = mem_rdata (combinational pass-through).
  - State returns to IDLE at t+2+MEM_LAT (read) or t+3 (write).
- Minimum spacing between issues is therefore MEM_LAT+2 cycles for reads and 3 cycles for writes.
- Requesters may change req or fields starting the cycle after ready. The arbiter never samples inputs outside IDLE, except if_abort.
- if_abort:
  - If asserted at any cycle during a granted fetch (ISSUE/WAIT/DONE), the abort flag is set (or abort is seen directly in DONE).
  - The memory access still completes, but if_ready stays 0.
  - The flag clears on return to IDLE.
  - The pipeline re-issues the new fetch afterwards.
- Simultaneous events:
  - d_req and if_req in the same IDLE cycle: data wins, subject to the streak rule.
  - if_abort has no effect on a data transaction.
- Invariants:
  - Never two grants outstanding.
  - if_ready and d_ready are never both 1.
  - mem_en is never high in two consecutive cycles.

Test Plan:
- Read latency and abort:
  - With MEM_LAT=2, if_req=1, if_addr=0x0040_0000 at cycle 0: mem_en=1 at cycle 1 with mem_addr=0x0040_0000 and mem_we=0; if_ready=1 at cycle 3 with if_rdata=mem_rdata.
  - Repeat with if_abort pulsed at cycle 2: mem_en still at 1, if_ready never rises, state back in IDLE at cycle 4.
- Simultaneous requests: if_req and d_req (lw 0x1000_0004) both at cycle 0. Data granted first (mem_addr=0x1000_0004, d_ready at 3). IDLE at 4; fetch issued at 5, if_ready at 7.
- Store timing: d_req=1, d_we=1, d_addr=0x1000_0008, d_wdata=0xDEADBEEF at cycle 0. mem_en=1 and mem_we=1 at cycle 1 with mem_wdata=0xDEADBEEF; d_ready=1 at cycle 2; if_ready stays 0.
- Streak limiter: if_req held high, d_req held high for 4 transactions. With MAX_D_STREAK=2, grant order is D, D, I, D. Streak is 2 before the third arbitration and 0 after the fetch.
- Reset mid-transaction: assert rst_n=0 during WAIT of a load. All outputs are 0 immediately, asynchronously, and no d_ready follows. After release with d_req still high, the load re-issues from IDLE.
